acc_delta_decoder: RTL and testbench
====================================

// Module: acc_delta_decoder
// PURPOSE
//  Inverse of the two-input summing accumulator: takes the accumulated sample stream
//  (o_data plus wrap flag) and recovers the per-cycle increment that was added.
//  Sits downstream of the accumulator.
//  - Uses a valid/ready handshake on both sides.
//  - Flags increments outside the legal sum range (0 .. 2*(2^NB_INPUT-1)).
// PARAMETERS
//  NB_INPUT  3           width of each accumulator input operand
//  NB_ACC    NB_INPUT+4  width of the accumulated sample
//  NB_CNT    8           width of the emitted-delta counter
// PORTS
//  clock       in   1           single clock, rising edge
//  i_reset     in   1           asynchronous, active-high reset
//  i_clear     in   1           synchronous restart: drop reference, return to IDLE
//  i_data      in   NB_ACC      accumulated sample
//  i_overflow  in   1           sample wrapped modulo 2^NB_ACC since previous sample
//  i_valid     in   1           input sample valid
//  o_ready     out  1           decoder can accept a sample this cycle
//  o_delta     out  NB_INPUT+1  recovered increment (unsigned)
//  o_range_err out  1           delta exceeds 2*(2^NB_INPUT-1); qualifies o_delta
//  o_valid     out  1           o_delta/o_range_err valid
//  i_ready     in   1           downstream accepts o_delta
//  o_count     out  NB_CNT      number of deltas emitted, saturating at all-ones
// BEHAVIOUR
//  - Reset (async): state=IDLE, ref=0, o_delta=0, o_range_err=0, o_valid=0, o_count=0.
//  - Input transfer occurs when i_valid && o_ready.
//  - Output transfer occurs when o_valid && i_ready.
//  - o_ready = !o_valid || i_ready (combinational). Single output register, no skid.
//  - FSM states:
//    - IDLE: on the first input transfer, ref<=i_data and go to RUN. No output is
//      produced and i_overflow is ignored.
//    - RUN: each input transfer computes
//        full = i_overflow ? ({1'b1,i_data} - {1'b0,ref}) : ({1'b0,i_data} - {1'b0,ref})
//      full is NB_ACC+1 bits.
//      - If i_overflow=0 and i_data < ref, the result is negative: o_range_err=1 and
//        o_delta=0.
//      - Otherwise o_delta = full[NB_INPUT:0] and o_range_err = (full > 2*(2^NB_INPUT-1)).
//      - On the same edge: ref<=i_data, o_valid<=1. Latency is 1 cycle.
//  - o_valid drops on an output transfer with no simultaneous input transfer.
//    - Simultaneous output and input transfer: new delta loaded, o_valid stays 1.
//  - o_delta and o_range_err hold stable while o_valid && !i_ready.
//  - o_count increments on each output transfer and saturates at 2^NB_CNT-1.
//  - i_clear: takes priority over any input transfer in the same cycle.
//    - Next state IDLE, o_valid<=0, o_count<=0, ref<=0.
//    - Any pending delta is discarded.
//  - Reset asserted mid-stream clears all state immediately, regardless of clock.
// TESTING
//  - Reset, then samples 0,5,12,20 (no ovf), i_ready=1:
//    -> deltas 5,7,8 with 1-cycle latency, o_count=3.
//  - ref=120, sample 6 with i_overflow=1 -> o_delta=14 (134-120), o_range_err=0.
//  - ref=10, sample 30 -> full=20 > 14: o_range_err=1.
//    - Also ref=10, sample 4 with no ovf -> o_range_err=1, o_delta=0.
//  - Backpressure: i_ready=0 for 3 cycles after a delta.
//    -> o_valid held, o_delta stable, o_ready=0.
//    -> Releasing i_ready with i_valid=1 gives a back-to-back transfer.
//  - Assert i_clear while o_valid=1 with i_valid=1.
//    -> o_valid=0, o_count=0, next sample only primes ref with no delta.
//  - Async i_reset pulse between clock edges mid-run.
//    -> all outputs zero at once; 300 samples -> o_count saturates at 255.

Source files
------------

// File: rtl/acc_delta_decoder.sv
// acc_delta_decoder: recovers the per-cycle increment from an accumulated
// sample stream (sample plus wrap flag) behind a valid/ready handshake on both
// sides. The first sample after reset or clear only primes the reference.
module acc_delta_decoder #(
  parameter int NB_INPUT = 3,
  parameter int NB_ACC   = NB_INPUT + 4,
  parameter int NB_CNT   = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic [NB_ACC-1:0]   i_data,
  input  logic                i_overflow,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [NB_INPUT:0]   o_delta,
  output logic                o_range_err,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NB_CNT-1:0]   o_count
);

  localparam int NB_FULL = NB_ACC + 1;
  // Largest legal increment: sum of two full-scale operands.
  localparam logic [NB_FULL-1:0] MAX_SUM = NB_FULL'(2 * ((1 << NB_INPUT) - 1));

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [NB_ACC-1:0]   ref_p0;
  logic [NB_INPUT:0]   delta_p1;
  logic                err_p1;
  logic                vld_p1;
  logic [NB_CNT-1:0]   cnt_p1;

  logic                in_xfer;
  logic                out_xfer;
  logic                emit;
  logic                negative;
  logic [NB_FULL-1:0]  full;

  // Modular difference; the wrap flag supplies the borrowed top bit.
  function automatic logic [NB_FULL-1:0] wrap_diff(
    input logic [NB_ACC-1:0] cur,
    input logic [NB_ACC-1:0] prev,
    input logic              ovf
  );
    return {ovf, cur} - {1'b0, prev};
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign o_ready     = !vld_p1 || i_ready;
  assign in_xfer     = i_valid && o_ready;
  assign out_xfer    = vld_p1 && i_ready;
  assign full        = wrap_diff(i_data, ref_p0, i_overflow);
  // Without a wrap, a sample below the reference cannot come from the accumulator.
  assign negative    = !i_overflow && (i_data < ref_p0);

  assign o_delta     = delta_p1;
  assign o_range_err = err_p1;
  assign o_valid     = vld_p1;
  assign o_count     = cnt_p1;

  // State register.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state; clear overrides any accepted sample, first sample primes only.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (i_clear) begin
      state_nxt = IDLE;
    end else if (in_xfer) begin
      state_nxt = RUN;
      emit      = (state == RUN);
    end
  end

  // Reference, output register and emitted-delta counter.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      ref_p0   <= '0;
      delta_p1 <= '0;
      err_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else if (i_clear) begin
      ref_p0   <= '0;
      vld_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      if (out_xfer) cnt_p1 <= sat_inc(cnt_p1);
      if (in_xfer)  ref_p0 <= i_data;
      if (emit) begin
        vld_p1 <= 1'b1;
        if (negative) begin
          delta_p1 <= '0;
          err_p1   <= 1'b1;
        end else begin
          delta_p1 <= full[NB_INPUT:0];
          err_p1   <= (full > MAX_SUM);
        end
      end else if (out_xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_delta_decoder.sv
// Directed bench for acc_delta_decoder with an integer reference model and a
// per-cycle compare on the falling edge.
module tb_acc_delta_decoder;

  localparam int NB_INPUT = 3;
  localparam int NB_ACC   = NB_INPUT + 4;
  localparam int NB_CNT   = 8;
  localparam int MOD      = 1 << NB_ACC;
  localparam int DMOD     = 1 << (NB_INPUT + 1);
  localparam int MAXSUM   = 2 * ((1 << NB_INPUT) - 1);
  localparam int CNTMAX   = (1 << NB_CNT) - 1;

  logic                clock = 1'b0;
  logic                i_reset;
  logic                i_clear = 1'b0;
  logic [NB_ACC-1:0]   i_data = '0;
  logic                i_overflow = 1'b0;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic [NB_INPUT:0]   o_delta;
  logic                o_range_err;
  logic                o_valid;
  logic                i_ready = 1'b1;
  logic [NB_CNT-1:0]   o_count;

  int checks = 0;
  int failures = 0;

  acc_delta_decoder #(.NB_INPUT(NB_INPUT), .NB_ACC(NB_ACC), .NB_CNT(NB_CNT)) dut (
    .clock(clock), .i_reset(i_reset), .i_clear(i_clear), .i_data(i_data),
    .i_overflow(i_overflow), .i_valid(i_valid), .o_ready(o_ready),
    .o_delta(o_delta), .o_range_err(o_range_err), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the stream, no notion of the RTL FSM.
  bit m_run = 0;
  int m_ref = 0;
  bit exp_valid = 0;
  int exp_delta = 0;
  bit exp_err = 0;
  int exp_count = 0;

  always @(posedge clock or posedge i_reset) begin : mdl
    bit in_x, out_x, n_run, n_valid, n_err;
    int full, n_ref, n_delta, n_count;
    if (i_reset) begin
      m_run <= 0; m_ref <= 0; exp_valid <= 0; exp_delta <= 0;
      exp_err <= 0; exp_count <= 0;
    end else begin
      n_run = m_run; n_ref = m_ref; n_valid = exp_valid;
      n_delta = exp_delta; n_err = exp_err; n_count = exp_count;
      out_x = exp_valid && i_ready;
      in_x  = i_valid && (!exp_valid || i_ready);
      if (i_clear) begin
        n_run = 0; n_ref = 0; n_valid = 0; n_count = 0;
      end else begin
        if (out_x) begin
          if (n_count < CNTMAX) n_count++;
          n_valid = 0;
        end
        if (in_x) begin
          if (m_run) begin
            full = int'(i_data) + (i_overflow ? MOD : 0) - m_ref;
            if (full < 0) begin
              n_delta = 0; n_err = 1;
            end else begin
              n_delta = full % DMOD; n_err = (full > MAXSUM);
            end
            n_valid = 1;
          end
          n_run = 1;
          n_ref = int'(i_data);
        end
      end
      m_run <= n_run; m_ref <= n_ref; exp_valid <= n_valid;
      exp_delta <= n_delta; exp_err <= n_err; exp_count <= n_count;
    end
  end

  always @(negedge clock) begin
    check("cmp_valid", int'(o_valid), int'(exp_valid));
    check("cmp_ready", int'(o_ready), int'(!exp_valid || i_ready));
    check("cmp_count", int'(o_count), exp_count);
    if (exp_valid) begin
      check("cmp_delta", int'(o_delta), exp_delta);
      check("cmp_err", int'(o_range_err), int'(exp_err));
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input bit v, input int d, input bit ovf, input bit rdy, input bit clr);
    i_valid = v; i_data = NB_ACC'(d); i_overflow = ovf; i_ready = rdy; i_clear = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc, inc, nxt;
    i_reset = 1'b1;
    #3;
    check("rst_valid", int'(o_valid), 0);
    check("rst_delta", int'(o_delta), 0);
    check("rst_err", int'(o_range_err), 0);
    check("rst_count", int'(o_count), 0);
    #9 i_reset = 1'b0;
    @(posedge clock); #1;

    // Basic stream: 0 primes, then deltas 5, 7, 8.
    step(1, 0, 0, 1, 0);
    check("prime_no_out", int'(o_valid), 0);
    step(1, 5, 0, 1, 0);
    check("d5", int'(o_delta), 5);
    step(1, 12, 0, 1, 0);
    check("d7", int'(o_delta), 7);
    step(1, 20, 0, 1, 0);
    check("d8", int'(o_delta), 8);
    step(0, 0, 0, 1, 0);
    check("count3", int'(o_count), 3);
    check("drained", int'(o_valid), 0);

    // Wrapped sample: ref 120, sample 6 with overflow -> 14.
    step(1, 120, 0, 1, 0);
    step(1, 6, 1, 1, 0);
    check("ovf_delta", int'(o_delta), 14);
    check("ovf_err", int'(o_range_err), 0);

    // Range errors: too large, then negative.
    step(1, 10, 0, 1, 0);
    check("d4_ok", int'(o_delta), 4);
    step(1, 30, 0, 1, 0);
    check("big_err", int'(o_range_err), 1);
    step(1, 10, 0, 1, 0);
    step(1, 4, 0, 1, 0);
    check("neg_err", int'(o_range_err), 1);
    check("neg_delta", int'(o_delta), 0);

    // Backpressure, with one offered sample that must not be taken.
    step(1, 7, 0, 1, 0);
    check("bp_first", int'(o_delta), 3);
    for (int k = 0; k < 3; k++) begin
      step(k == 1, 100, 0, 0, 0);
      check("bp_hold_valid", int'(o_valid), 1);
      check("bp_hold_delta", int'(o_delta), 3);
      check("bp_ready_low", int'(o_ready), 0);
    end
    step(1, 9, 0, 1, 0);
    check("b2b_valid", int'(o_valid), 1);
    check("b2b_delta", int'(o_delta), 2);

    // Clear while a delta is pending and a sample is offered.
    step(1, 50, 0, 1, 1);
    check("clr_valid", int'(o_valid), 0);
    check("clr_count", int'(o_count), 0);
    step(1, 60, 0, 1, 0);
    check("clr_prime", int'(o_valid), 0);
    step(1, 63, 0, 1, 0);
    check("clr_after", int'(o_delta), 3);

    // Asynchronous reset pulse between edges.
    #1 i_reset = 1'b1;
    #1;
    check("arst_valid", int'(o_valid), 0);
    check("arst_delta", int'(o_delta), 0);
    check("arst_count", int'(o_count), 0);
    #1 i_reset = 1'b0;

    // Long run of 300 samples to saturate the counter.
    acc = 0;
    for (int n = 0; n < 300; n++) begin
      inc = n % (MAXSUM + 1);
      nxt = acc + inc;
      step(1, nxt % MOD, nxt >= MOD, 1, 0);
      acc = nxt % MOD;
    end
    step(0, 0, 0, 1, 0);
    check("sat_count", int'(o_count), CNTMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
